memory_cycle: RTL and testbench

Memory-access pipeline stage of the five-stage RISC-V core. It takes the instruction in M, performs RV32I byte/halfword/word loads and stores against an internal data memory, and registers the results into the MEM/WB pipeline register. The writeback stage consumes those registered outputs and selects the register-file result from them with ResultSrc_W. The block also handles pipeline stall and flush for the MEM/WB register and flags misaligned accesses.

---
 rtl/memory_cycle.sv | 130 +++++++++++++
 tb/tb_memory_cycle.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/memory_cycle.sv
// Memory-access stage of the five-stage RV32I pipeline: byte/half/word loads and
// stores against an internal data memory, feeding the MEM/WB pipeline register.
module memory_cycle #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_M,
  input  logic [1:0]  ResultSrc_M,
  input  logic        MemWrite_M,
  input  logic [2:0]  funct3_M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4_M,
  input  logic [31:0] ALU_Result_M,
  input  logic [31:0] WriteData_M,
  input  logic        Stall_M,
  input  logic        Flush_W,
  output logic        RegWrite_W,
  output logic [1:0]  ResultSrc_W,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4_W,
  output logic [31:0] ALU_Result_W,
  output logic [31:0] ReadData_W,
  output logic        Misaligned_W
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0]   r_mem [DMEM_WORDS];

  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_is_load;
  logic          w_mis_half;
  logic          w_mis_word;
  logic          w_mis;
  logic          w_store_en;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_load_val;

  // Upper address bits are dropped, so the memory aliases modulo DMEM_WORDS.
  assign w_idx     = ALU_Result_M[AW+1:2];
  assign w_lane    = ALU_Result_M[1:0];
  assign w_word    = r_mem[w_idx];
  assign w_byte    = w_word[{w_lane, 3'b000} +: 8];
  assign w_half    = w_lane[1] ? w_word[31:16] : w_word[15:0];
  assign w_is_load = (ResultSrc_M == 2'b01);

  assign w_mis_half = ALU_Result_M[0] &
                      ((w_is_load & ((funct3_M == 3'b001) | (funct3_M == 3'b101))) |
                       (MemWrite_M & (funct3_M == 3'b001)));
  assign w_mis_word = (ALU_Result_M[1:0] != 2'b00) & (funct3_M == 3'b010) &
                      (w_is_load | MemWrite_M);
  assign w_mis      = w_mis_half | w_mis_word;

  assign w_store_en = MemWrite_M & ~Stall_M & ~rst & ~w_mis;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    case (funct3_M)
      3'b000: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{WriteData_M[7:0]}};
      end
      3'b001: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteData_M[15:0]}};
      end
      3'b010: begin
        w_be    = 4'b1111;
        w_wdata = WriteData_M;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
      end
    endcase
  end

  always_comb begin
    w_load_val = 32'h0;
    if (w_is_load) begin
      case (funct3_M)
        3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
        3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
        3'b010:  w_load_val = w_word;
        3'b100:  w_load_val = {24'h0, w_byte};
        3'b101:  w_load_val = {16'h0, w_half};
        default: w_load_val = 32'h0;
      endcase
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || Flush_W) begin
      RegWrite_W   <= 1'b0;
      ResultSrc_W  <= 2'b00;
      RD_W         <= 5'd0;
      PCPlus4_W    <= 32'h0;
      ALU_Result_W <= 32'h0;
      ReadData_W   <= 32'h0;
      Misaligned_W <= 1'b0;
    end else if (!Stall_M) begin
      RegWrite_W   <= RegWrite_M & ~w_mis;
      ResultSrc_W  <= ResultSrc_M;
      RD_W         <= RD_M;
      PCPlus4_W    <= PCPlus4_M;
      ALU_Result_W <= ALU_Result_M;
      ReadData_W   <= w_mis ? 32'h0 : w_load_val;
      Misaligned_W <= w_mis;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: the driver queues the expected MEM/WB state
// after each edge, and a negedge monitor pops and compares it.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_M;
  logic [1:0]  ResultSrc_M;
  logic        MemWrite_M;
  logic [2:0]  funct3_M;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4_M;
  logic [31:0] ALU_Result_M;
  logic [31:0] WriteData_M;
  logic        Stall_M;
  logic        Flush_W;
  logic        RegWrite_W;
  logic [1:0]  ResultSrc_W;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4_W;
  logic [31:0] ALU_Result_W;
  logic [31:0] ReadData_W;
  logic        Misaligned_W;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        mis;
  } wb_t;

  wb_t  exp_q[$];
  wb_t  last_exp;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic [31:0] pc = 32'h0;

  memory_cycle #(.DMEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M), .MemWrite_M(MemWrite_M),
    .funct3_M(funct3_M), .RD_M(RD_M), .PCPlus4_M(PCPlus4_M),
    .ALU_Result_M(ALU_Result_M), .WriteData_M(WriteData_M),
    .Stall_M(Stall_M), .Flush_W(Flush_W),
    .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W), .RD_W(RD_W),
    .PCPlus4_W(PCPlus4_W), .ALU_Result_W(ALU_Result_W),
    .ReadData_W(ReadData_W), .Misaligned_W(Misaligned_W)
  );

  always #5 clk = ~clk;

  // Monitor: the W outputs are live every cycle, so each queued entry is checked.
  always @(negedge clk) begin
    wb_t act;
    wb_t e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = '{RegWrite_W, ResultSrc_W, RD_W, PCPlus4_W, ALU_Result_W, ReadData_W, Misaligned_W};
      n_tests++;
      cyc++;
      if (act !== e) begin
        n_fail++;
        $display("[TB] FAIL wb_cyc%0d: got rw=%0b rs=%0d rd=%0d pc4=%h alu=%h rdata=%h mis=%0b, want rw=%0b rs=%0d rd=%0d pc4=%h alu=%h rdata=%h mis=%0b",
                 cyc, act.rw, act.rs, act.rd, act.pc4, act.alu, act.rdata, act.mis,
                 e.rw, e.rs, e.rd, e.pc4, e.alu, e.rdata, e.mis);
      end else begin
        $display("[TB] ok  wb_cyc%0d: rw=%0b rd=%0d alu=%h rdata=%h mis=%0b",
                 cyc, act.rw, act.rd, act.alu, act.rdata, act.mis);
      end
    end
  end

  // One M-stage transaction; erd/emis are the hand-computed load result and misalignment.
  task automatic issue(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic stall, input logic flush, input logic rstv,
                       input logic [31:0] erd, input logic emis);
    wb_t e;
    pc           = pc + 32'd4;
    rst          = rstv;
    RegWrite_M   = rw;
    ResultSrc_M  = rs;
    MemWrite_M   = mw;
    funct3_M     = f3;
    RD_M         = rd;
    PCPlus4_M    = pc;
    ALU_Result_M = addr;
    WriteData_M  = wdata;
    Stall_M      = stall;
    Flush_W      = flush;
    if (rstv || flush) e = '0;
    else if (stall)    e = last_exp;
    else               e = '{rw & ~emis, rs, rd, pc, addr, erd, emis};
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] data, input logic emis);
    issue(1'b0, 2'b00, 1'b1, f3, 5'd0, addr, data, 1'b0, 1'b0, 1'b0, 32'h0, emis);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                    input logic [31:0] erd, input logic emis);
    issue(1'b1, 2'b01, 1'b0, f3, rd, addr, 32'h0, 1'b0, 1'b0, 1'b0, erd, emis);
  endtask

  initial begin
    int waited;
    last_exp = '0;
    // Reset, with a store in flight that must not land.
    issue(1'b0, 2'b00, 1'b1, 3'b010, 5'd0, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);

    st(3'b010, 32'h10, 32'h8899_AABB, 1'b0);
    ld(3'b010, 32'h10, 5'd5, 32'h8899_AABB, 1'b0);
    st(3'b000, 32'h12, 32'h1234_567F, 1'b0);          // word -> 887FAABB
    ld(3'b000, 32'h12, 5'd6,  32'h0000_007F, 1'b0);
    ld(3'b000, 32'h11, 5'd7,  32'hFFFF_FFAA, 1'b0);
    ld(3'b100, 32'h11, 5'd8,  32'h0000_00AA, 1'b0);
    ld(3'b001, 32'h12, 5'd9,  32'hFFFF_887F, 1'b0);   // bit 15 of 0x887F is set
    ld(3'b101, 32'h12, 5'd10, 32'h0000_887F, 1'b0);
    ld(3'b101, 32'h10, 5'd11, 32'h0000_AABB, 1'b0);
    ld(3'b010, 32'h13, 5'd12, 32'h0, 1'b1);           // misaligned LW
    st(3'b001, 32'h11, 32'h0000_DEAD, 1'b1);          // misaligned SH, suppressed
    ld(3'b010, 32'h10, 5'd13, 32'h887F_AABB, 1'b0);
    ld(3'b001, 32'h11, 5'd14, 32'h0, 1'b1);           // misaligned LH
    st(3'b001, 32'h12, 32'h1111_BEEF, 1'b0);          // word -> BEEFAABB
    ld(3'b010, 32'h10, 5'd15, 32'hBEEF_AABB, 1'b0);
    ld(3'b001, 32'h10, 5'd16, 32'hFFFF_AABB, 1'b0);
    ld(3'b011, 32'h10, 5'd17, 32'h0, 1'b0);           // reserved load code
    issue(1'b1, 2'b00, 1'b0, 3'b010, 5'd18, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Store held in M by a 3-cycle stall, then released.
    st(3'b010, 32'h20, 32'h0102_0304, 1'b0);
    ld(3'b010, 32'h20, 5'd7, 32'h0102_0304, 1'b0);
    for (int i = 0; i < 3; i++)
      issue(1'b0, 2'b00, 1'b1, 3'b010, 5'd0, 32'h20, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    st(3'b010, 32'h20, 32'hCAFE_F00D, 1'b0);
    ld(3'b010, 32'h20, 5'd19, 32'hCAFE_F00D, 1'b0);

    // Flush together with stall: bubble, and the store never lands.
    st(3'b010, 32'h24, 32'h1111_1111, 1'b0);
    issue(1'b1, 2'b00, 1'b1, 3'b010, 5'd9, 32'h24, 32'h0000_0055, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    ld(3'b010, 32'h24, 5'd20, 32'h1111_1111, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 3'b010, 5'd21, 32'h24, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

    // Reset during a store, then aliasing modulo the memory depth.
    st(3'b010, 32'h40, 32'hA5A5_A5A5, 1'b0);
    issue(1'b1, 2'b00, 1'b1, 3'b010, 5'd3, 32'h40, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    ld(3'b010, 32'h40, 5'd22, 32'hA5A5_A5A5, 1'b0);
    ld(3'b010, 32'h1040, 5'd23, 32'hA5A5_A5A5, 1'b0);
    st(3'b010, 32'h1044, 32'h0000_0077, 1'b0);
    ld(3'b010, 32'h44, 5'd24, 32'h0000_0077, 1'b0);

    issue(1'b0, 2'b00, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
